mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1: ACCESS-state length in cycles, legal 1..15.
REQ-002 SHALL have ports `clock` (in, 1) and `reset` (in, 1); one clock; reset asynchronous, active-high.
REQ-003 SHALL have `cpu_req` (in, 1): access request level.
REQ-004 SHALL have `cpu_addr` (in, 16) and `cpu_rw` (in, 1); `cpu_rw` is 1 for read.
REQ-005 SHALL have `cpu_wdata` (in, 8): write data.
REQ-006 SHALL have `cpu_rdata` (out, 8): registered read data.
REQ-007 SHALL have `cpu_ready` (out, 1): one-cycle completion pulse.
REQ-008 SHALL have `rom_address` (out, 11), `rom_select` (out, 1) and `rom_data` (in, 8): drives the 2K synchronous-read ROM.
REQ-009 SHALL have `ram_address` (out, 11), `ram_select` (out, 1), `ram_we` (out, 1), `ram_wdata` (out, 8) and `ram_rdata` (in, 8): 2K RAM port.
REQ-010 SHALL have `rom_write_err` (out, 1): sticky flag for attempted ROM writes.

Function
REQ-011 Memory map SHALL be: RAM 0x0000-0x07FF; ROM 0xF800-0xFFFF; all other addresses unmapped.
REQ-012 FSM states SHALL be IDLE, ACCESS, CAPTURE and DONE.
REQ-013 In IDLE with `cpu_req`=1 at edge N, SHALL latch addr, rw and wdata, load the wait counter with WAIT_STATES, and enter ACCESS at N+1.
REQ-014 ACCESS SHALL last exactly WAIT_STATES cycles, then enter CAPTURE (one cycle), then DONE (one cycle), then IDLE.
REQ-015 `cpu_ready` SHALL be 1 only in DONE, first at cycle N+2+WAIT_STATES (N+3 at default).
REQ-016 `rom_select` or `ram_select` SHALL be registered and high for the decoded region throughout ACCESS and CAPTURE; otherwise low.
REQ-017 `rom_address` and `ram_address` SHALL carry latched addr[10:0] from N+1 until the next acceptance.
REQ-018 `cpu_rdata` SHALL be loaded at the CAPTURE-exit edge: `rom_data`, `ram_rdata`, or 0xFF when unmapped; it holds until the next capture.
REQ-019 For a RAM write, `ram_we` SHALL pulse only in the first ACCESS cycle, with `ram_wdata` equal to the latched wdata.
REQ-020 A write to ROM SHALL assert no `rom_select`, SHALL set `rom_write_err`, and SHALL complete with a normal `cpu_ready`.
REQ-021 A write to an unmapped address SHALL complete with no select and no error.
REQ-022 Writes SHALL leave `cpu_rdata` unchanged.
REQ-023 `cpu_req` SHALL be ignored outside IDLE; inputs are sampled only at acceptance.
REQ-024 If `cpu_req` is held high through DONE, a new access SHALL be accepted on the DONE-to-IDLE return edge, giving period 3+WAIT_STATES.
REQ-025 Address boundaries SHALL be exact: 0x07FF is RAM, 0x0800 is unmapped, 0xF7FF is unmapped, 0xF800 is ROM and 0xFFFF is ROM.

Reset
REQ-026 On reset: state IDLE; `cpu_ready`, all selects and `ram_we` 0; `cpu_rdata` 0xFF; addresses 0; `rom_write_err` 0; counter 0.
REQ-027 Reset asserted mid-access SHALL abort immediately with no `cpu_ready` pulse and no further `ram_we`.
REQ-028 After reset release, the first acceptance SHALL occur no earlier than the first edge with `cpu_req`=1.

Structure
REQ-029 Package mem_map_pkg SHALL hold the region base/size constants, the state enum and the region enum (RAM, ROM, NONE).
REQ-030 Region decode SHALL be one combinational sub-module, mem_region_decode (addr in, region out), instantiated once.

Verification
REQ-031 Read 0xF800 with ROM word 0 = 0x12, WAIT_STATES=1 -> `rom_select` high N+1..N+2, `rom_address`=0x000, `cpu_ready` at N+3, `cpu_rdata`=0x12.
REQ-032 Write 0x0005 with data 0xA5, then read 0x0005 -> `ram_we` one cycle with `ram_address`=0x005; the read returns 0xA5.
REQ-033 Read 0x0800 and read 0xF7FF -> no select, `cpu_rdata`=0xFF, `cpu_ready` at N+3.
REQ-034 Write 0xFFFF -> `rom_write_err`=1 and stays 1; `rom_select` never asserts; `cpu_ready` still pulses.
REQ-035 WAIT_STATES=4 with `cpu_req` held high across two reads -> ready pulses exactly 7 cycles apart.
REQ-036 Reset asserted during CAPTURE -> selects drop asynchronously, `cpu_rdata`=0xFF, no `cpu_ready`, state IDLE.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Shared memory-map constants, FSM state and region types for the CPU memory bus controller.
package mem_map_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned OFFS_W = 11;
    localparam int unsigned DATA_W = 8;

    localparam logic [ADDR_W-1:0] RAM_BASE = 16'h0000;
    localparam logic [ADDR_W-1:0] RAM_SIZE = 16'h0800;
    localparam logic [ADDR_W-1:0] ROM_BASE = 16'hF800;
    localparam logic [ADDR_W-1:0] ROM_SIZE = 16'h0800;

    localparam logic [DATA_W-1:0] UNMAPPED_DATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RAM,
        ROM,
        NONE
    } region_t;

    // Wrapping subtraction makes the base-0 and top-of-space windows compare uniformly.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W-1:0] size);
        return (addr - base) < size;
    endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational address-to-region decoder for the CPU memory map.
module mem_region_decode
    import mem_map_pkg::*;
(
    input  logic [ADDR_W-1:0] addr_i,
    output region_t           region_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives region_o and no latch is inferred.
        region_o = NONE;
        if (in_window(addr_i, RAM_BASE, RAM_SIZE)) begin
            region_o = RAM;
        end else if (in_window(addr_i, ROM_BASE, ROM_SIZE)) begin
            region_o = ROM;
        end
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU-to-ROM/RAM bus controller: latches a request, runs WAIT_STATES access cycles,
// captures read data and pulses cpu_ready once per transfer.
module mem_bus_ctrl
    import mem_map_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rw,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic [OFFS_W-1:0] rom_address,
    output logic              rom_select,
    input  logic [DATA_W-1:0] rom_data,
    output logic [OFFS_W-1:0] ram_address,
    output logic              ram_select,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              rom_write_err
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t              state_q;
    region_t             region_q;
    region_t             req_region;
    logic                rw_q;
    logic [OFFS_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [3:0]          wait_q;
    logic                ready_q;
    logic                rom_sel_q;
    logic                ram_sel_q;
    logic                ram_we_q;
    logic                rom_err_q;

    mem_region_decode u_decode (
        .addr_i   (cpu_addr),
        .region_o (req_region)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            region_q  <= NONE;
            rw_q      <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= UNMAPPED_DATA;
            wait_q    <= '0;
            ready_q   <= 1'b0;
            rom_sel_q <= 1'b0;
            ram_sel_q <= 1'b0;
            ram_we_q  <= 1'b0;
            rom_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ready_q  <= 1'b0;
            ram_we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q    <= cpu_addr[OFFS_W-1:0];
                        rw_q      <= cpu_rw;
                        wdata_q   <= cpu_wdata;
                        region_q  <= req_region;
                        wait_q    <= WAIT_LOAD;
                        rom_sel_q <= (req_region == ROM) && cpu_rw;
                        ram_sel_q <= (req_region == RAM);
                        ram_we_q  <= (req_region == RAM) && !cpu_rw;
                        if ((req_region == ROM) && !cpu_rw) begin
                            rom_err_q <= 1'b1;
                        end
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    wait_q <= wait_q - 4'd1;
                    if (wait_q <= 4'd1) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rom_sel_q <= 1'b0;
                    ram_sel_q <= 1'b0;
                    if (rw_q) begin
                        case (region_q)
                            RAM:     rdata_q <= ram_rdata;
                            ROM:     rdata_q <= rom_data;
                            default: rdata_q <= UNMAPPED_DATA;
                        endcase
                    end
                    ready_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata     = rdata_q;
    assign cpu_ready     = ready_q;
    assign rom_address   = addr_q;
    assign rom_select    = rom_sel_q;
    assign ram_address   = addr_q;
    assign ram_select    = ram_sel_q;
    assign ram_we        = ram_we_q;
    assign ram_wdata     = wdata_q;
    assign rom_write_err = rom_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomised self-checking bench for mem_bus_ctrl: unit 0 runs WAIT_STATES=1, unit 1 WAIT_STATES=4.
module tb_mem_bus_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        cpu_req       [2];
    logic [15:0] cpu_addr      [2];
    logic        cpu_rw        [2];
    logic [7:0]  cpu_wdata     [2];
    logic [7:0]  cpu_rdata     [2];
    logic        cpu_ready     [2];
    logic [10:0] rom_address   [2];
    logic        rom_select    [2];
    logic [7:0]  rom_data      [2];
    logic [10:0] ram_address   [2];
    logic        ram_select    [2];
    logic        ram_we        [2];
    logic [7:0]  ram_wdata     [2];
    logic [7:0]  ram_rdata     [2];
    logic        rom_write_err [2];

    logic [7:0] rom_mem   [2048];
    logic [7:0] ram_mem   [2][2048];
    logic [7:0] model_ram [2][2048];
    logic [7:0] exp_rdata [2];
    logic       exp_err   [2];

    int tests_run    = 0;
    int tests_failed = 0;

    for (genvar g = 0; g < 2; g++) begin : g_unit
        mem_bus_ctrl #(.WAIT_STATES(g == 0 ? 1 : 4)) u_dut (
            .clock         (clk),
            .reset         (rst),
            .cpu_req       (cpu_req[g]),
            .cpu_addr      (cpu_addr[g]),
            .cpu_rw        (cpu_rw[g]),
            .cpu_wdata     (cpu_wdata[g]),
            .cpu_rdata     (cpu_rdata[g]),
            .cpu_ready     (cpu_ready[g]),
            .rom_address   (rom_address[g]),
            .rom_select    (rom_select[g]),
            .rom_data      (rom_data[g]),
            .ram_address   (ram_address[g]),
            .ram_select    (ram_select[g]),
            .ram_we        (ram_we[g]),
            .ram_wdata     (ram_wdata[g]),
            .ram_rdata     (ram_rdata[g]),
            .rom_write_err (rom_write_err[g])
        );

        // Synchronous-read ROM and RAM, active only while selected.
        always @(posedge clk) begin
            if (rom_select[g]) rom_data[g] <= rom_mem[rom_address[g]];
            if (ram_select[g]) begin
                ram_rdata[g] <= ram_mem[g][ram_address[g]];
                if (ram_we[g]) ram_mem[g][ram_address[g]] <= ram_wdata[g];
            end
        end
    end

    function automatic int ws_of(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    // 0 = RAM, 1 = ROM, 2 = unmapped
    function automatic int region_of(input logic [15:0] a);
        if (a <= 16'h07FF) return 0;
        if (a >= 16'hF800) return 1;
        return 2;
    endfunction

    function automatic logic [15:0] rand_addr();
        logic [15:0] edges [6];
        edges = '{16'h0000, 16'h07FF, 16'h0800, 16'hF7FF, 16'hF800, 16'hFFFF};
        case ($urandom_range(0, 3))
            0:       return 16'($urandom_range(0, 2047));
            1:       return 16'h F800 + 16'($urandom_range(0, 2047));
            2:       return 16'($urandom_range(16'h0800, 16'hF7FF));
            default: return edges[$urandom_range(0, 5)];
        endcase
    endfunction

    // One complete transfer; checks controls every cycle until one cycle after DONE.
    task automatic run_access(input int u, input logic [15:0] a, input logic rw, input logic [7:0] wd);
        int ws;
        int rg;
        logic [3:0] exp_v;
        logic [3:0] got_v;
        ws = ws_of(u);
        rg = region_of(a);
        if (rw) exp_rdata[u] = (rg == 0) ? model_ram[u][a[10:0]] : (rg == 1) ? rom_mem[a[10:0]] : 8'hFF;
        else if (rg == 0) model_ram[u][a[10:0]] = wd;
        else if (rg == 1) exp_err[u] = 1'b1;

        @(negedge clk);
        cpu_req[u] = 1'b1; cpu_addr[u] = a; cpu_rw[u] = rw; cpu_wdata[u] = wd;
        for (int j = 1; j <= ws + 3; j++) begin
            @(negedge clk);
            exp_v = {rg == 1 && rw && j <= ws + 1, rg == 0 && j <= ws + 1, rg == 0 && !rw && j == 1, j == ws + 2};
            got_v = {rom_select[u], ram_select[u], ram_we[u], cpu_ready[u]};
            tests_run++;
            if (got_v !== exp_v) begin
                tests_failed++;
                $display("FAIL ctrl u%0d addr=%h rw=%0d cyc=%0d: {romsel,ramsel,we,ready} got %b want %b", u, a, rw, j, got_v, exp_v);
            end
            tests_run++;
            if ({rom_address[u], ram_address[u]} !== {a[10:0], a[10:0]}) begin
                tests_failed++;
                $display("FAIL address u%0d cyc=%0d: rom %h ram %h want %h", u, j, rom_address[u], ram_address[u], a[10:0]);
            end
            if (j == 1 && rg == 0 && !rw) begin
                tests_run++;
                if (ram_wdata[u] !== wd) begin
                    tests_failed++;
                    $display("FAIL ram_wdata u%0d addr=%h: got %h want %h", u, a, ram_wdata[u], wd);
                end
            end
            if (j == ws + 2) begin
                tests_run++;
                if (cpu_rdata[u] !== exp_rdata[u] || rom_write_err[u] !== exp_err[u]) begin
                    tests_failed++;
                    $display("FAIL result u%0d addr=%h rw=%0d: rdata %h err %b want rdata %h err %b",
                             u, a, rw, cpu_rdata[u], rom_write_err[u], exp_rdata[u], exp_err[u]);
                end
            end
            // Busy-phase noise: req stays high through ACCESS with garbage that must be ignored.
            cpu_req[u]   = (j <= ws);
            cpu_addr[u]  = 16'($urandom);
            cpu_rw[u]    = 1'($urandom);
            cpu_wdata[u] = 8'($urandom);
        end
        cpu_req[u] = 1'b0;
    endtask

    task automatic check_quiet(input string name, input int u);
        tests_run++;
        if ({cpu_ready[u], rom_select[u], ram_select[u], ram_we[u], rom_write_err[u]} !== 5'b0 ||
            cpu_rdata[u] !== 8'hFF || rom_address[u] !== 11'h0 || ram_address[u] !== 11'h0) begin
            tests_failed++;
            $display("FAIL %s u%0d: ready %b romsel %b ramsel %b we %b err %b rdata %h addr %h/%h want all 0, rdata ff",
                     name, u, cpu_ready[u], rom_select[u], ram_select[u], ram_we[u], rom_write_err[u],
                     cpu_rdata[u], rom_address[u], ram_address[u]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        for (int u = 0; u < 2; u++) check_quiet("reset_value", u);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) check_quiet("idle_after_reset", u);
        end
        for (int u = 0; u < 2; u++) begin
            exp_rdata[u] = 8'hFF;
            exp_err[u]   = 1'b0;
        end
    endtask

    task automatic test_rom_read();
        for (int u = 0; u < 2; u++) begin
            run_access(u, 16'hF800, 1'b1, 8'h00);
            run_access(u, 16'hF9A3, 1'b1, 8'h00);
        end
    endtask

    task automatic test_ram_write_read();
        for (int u = 0; u < 2; u++) begin
            run_access(u, 16'h0005, 1'b0, 8'hA5);
            run_access(u, 16'h0005, 1'b1, 8'h00);
        end
    endtask

    task automatic test_unmapped();
        for (int u = 0; u < 2; u++) begin
            run_access(u, 16'h0800, 1'b1, 8'h00);
            run_access(u, 16'hF7FF, 1'b1, 8'h00);
            run_access(u, 16'h0005, 1'b1, 8'h00);
            run_access(u, 16'h4321, 1'b0, 8'h77);
        end
    endtask

    task automatic test_boundaries();
        for (int u = 0; u < 2; u++) begin
            run_access(u, 16'h07FF, 1'b0, 8'hC3);
            run_access(u, 16'h07FF, 1'b1, 8'h00);
            run_access(u, 16'h0000, 1'b1, 8'h00);
            run_access(u, 16'hFFFF, 1'b1, 8'h00);
        end
    endtask

    task automatic test_rom_write();
        for (int u = 0; u < 2; u++) begin
            run_access(u, 16'hFFFF, 1'b0, 8'h5A);
            run_access(u, 16'hFFFF, 1'b1, 8'h00);
            run_access(u, 16'h0010, 1'b0, 8'h11);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            run_access($urandom_range(0, 1), rand_addr(), 1'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  ea;
        logic [7:0]  eb;
        int cyc;
        int t_first;
        int t_second;
        a  = 16'($urandom_range(0, 2047));
        b  = 16'hF800 + 16'($urandom_range(0, 2047));
        ea = model_ram[1][a[10:0]];
        eb = rom_mem[b[10:0]];
        cyc = 0; t_first = -1; t_second = -1;
        @(negedge clk);
        cpu_req[1] = 1'b1; cpu_addr[1] = a; cpu_rw[1] = 1'b1;
        while (t_second < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cpu_ready[1]) begin
                if (t_first < 0) begin
                    t_first = cyc;
                    tests_run++;
                    if (cpu_rdata[1] !== ea) begin
                        tests_failed++;
                        $display("FAIL b2b_first_data: got %h want %h", cpu_rdata[1], ea);
                    end
                    cpu_addr[1] = b;
                end else begin
                    t_second = cyc;
                    tests_run++;
                    if (cpu_rdata[1] !== eb) begin
                        tests_failed++;
                        $display("FAIL b2b_second_data: got %h want %h", cpu_rdata[1], eb);
                    end
                    cpu_req[1] = 1'b0;
                end
            end
        end
        cpu_req[1] = 1'b0;
        exp_rdata[1] = eb;
        tests_run++;
        if (t_first != 6) begin
            tests_failed++;
            $display("FAIL b2b_first_latency: got %0d want 6", t_first);
        end
        tests_run++;
        if (t_second < 0 || t_second - t_first != 7) begin
            tests_failed++;
            $display("FAIL b2b_period: got %0d want 7 (second=%0d)", t_second - t_first, t_second);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        run_access(0, 16'h0123, 1'b0, 8'h3C);
        run_access(0, 16'h0123, 1'b1, 8'h00);
        @(negedge clk);
        cpu_req[0] = 1'b1; cpu_addr[0] = 16'hF801; cpu_rw[0] = 1'b1;
        @(negedge clk);
        cpu_req[0] = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rom_select[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_abort_select: rom_select %b want 1", rom_select[0]);
        end
        #1 rst = 1'b1;
        #1;
        tests_run++;
        if ({rom_select[0], ram_select[0], cpu_ready[0]} !== 3'b000 || cpu_rdata[0] !== 8'hFF) begin
            tests_failed++;
            $display("FAIL async_abort: romsel %b ramsel %b ready %b rdata %h want 0 0 0 ff",
                     rom_select[0], ram_select[0], cpu_ready[0], cpu_rdata[0]);
        end
        repeat (3) begin
            @(negedge clk);
            check_quiet("held_reset", 0);
        end
        rst = 1'b0;
        exp_rdata[0] = 8'hFF; exp_err[0] = 1'b0;
        exp_rdata[1] = 8'hFF; exp_err[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_quiet("after_abort", 0);
        end
        run_access(0, 16'hF801, 1'b1, 8'h00);
        run_access(1, 16'h0123, 1'b1, 8'h00);
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            cpu_req[u] = 1'b0; cpu_addr[u] = 16'h0; cpu_rw[u] = 1'b1; cpu_wdata[u] = 8'h0;
            exp_rdata[u] = 8'hFF; exp_err[u] = 1'b0;
        end
        for (int i = 0; i < 2048; i++) begin
            rom_mem[i] = 8'($urandom);
            for (int u = 0; u < 2; u++) begin
                ram_mem[u][i]   = 8'($urandom);
                model_ram[u][i] = ram_mem[u][i];
            end
        end
        rom_mem[0] = 8'h12;

        test_reset();
        test_rom_read();
        test_ram_write_read();
        test_unmapped();
        test_boundaries();
        test_rom_write();
        test_random();
        test_back_to_back();
        test_reset_mid_access();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
